// File: rtl/apb_pkg.sv
// Shared types and constants for the APB arbiter-master: FSM state encoding,
// bus widths and the slave-index field carried in the top address bits.
package apb_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int SEL_HI = 63;
    localparam int SEL_LO = 62;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // {PSEL1,PSEL2} is decoded straight from the top two address bits
    function automatic logic [1:0] slave_index(input addr_t addr);
        return addr[SEL_HI:SEL_LO];
    endfunction

endpackage

// File: rtl/apb_arbiter_master_if.sv
// Requester-side handshake plus APB master bus for apb_arbiter_master.
// The master modport is the design's view; slave is the environment's view.
interface apb_arbiter_master_if;
    import apb_pkg::*;

    logic  req0, req1;
    logic  write0, write1;
    addr_t addr0, addr1;
    data_t wdata0, wdata1;
    logic  gnt0, gnt1;

    logic  rsp_valid;
    logic  rsp_id;
    data_t rsp_rdata;
    logic  rsp_err;

    logic  cs, PSEL1, PSEL2, PENABLE, PWRITE;
    addr_t PADDR;
    data_t PWDATA;
    data_t PRDATA;
    logic  PREADY, slverr;

    modport master (
        input  req0, req1, write0, write1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1,
        output rsp_valid, rsp_id, rsp_rdata, rsp_err,
        output cs, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, slverr
    );

    modport slave (
        output req0, req1, write0, write1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1,
        input  rsp_valid, rsp_id, rsp_rdata, rsp_err,
        input  cs, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, slverr
    );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter. The pointer remembers the last requester
// granted; a tie goes to the other one. Reset points at requester 1.
module apb_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q, last_d;

    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
            if (|gnt) begin
                last_d = gnt[1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_arbiter_master.sv
// Arbitrates two requesters onto a single APB master, one transfer in flight.
// Define APB_ARBITER_TIMEOUT_EN to force an error completion on a stuck slave.
module apb_arbiter_master
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    apb_arbiter_master_if.master  bus
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SETUP  = SETUP;
    localparam logic [1:0] S_ACCESS = ACCESS;

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       write_q, write_d;
    addr_t      addr_q, addr_d;
    data_t      wdata_q, wdata_d;

    logic [1:0] gnt;
    logic       arb_en;
    logic       in_idle, in_access, active;
    logic       done, timeout_hit;

    assign in_idle   = (state_q == S_IDLE);
    assign in_access = (state_q == S_ACCESS);
    assign active    = (state_q == S_SETUP) || in_access;

    // Grants are suppressed while reset is held so every output reads zero
    assign arb_en = in_idle & ~PRESET;

    apb_rr_arbiter u_arb (
        .clk    (PCLK),
        .rst    (PRESET),
        .enable (arb_en),
        .req    ({bus.req1, bus.req0}),
        .gnt    (gnt)
    );

`ifdef APB_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of ACCESS cycles already spent waiting
    assign timeout_hit = in_access & ~bus.PREADY &
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (in_access && !done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign done = in_access & (bus.PREADY | timeout_hit);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (|gnt) begin
                    state_d = S_SETUP;
                    owner_d = gnt[1];
                    write_d = gnt[1] ? bus.write1 : bus.write0;
                    addr_d  = gnt[1] ? bus.addr1  : bus.addr0;
                    wdata_d = gnt[1] ? bus.wdata1 : bus.wdata0;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.gnt0 = gnt[0];
    assign bus.gnt1 = gnt[1];

    // The APB side is driven from the latched request and forced to zero in IDLE
    assign bus.cs      = active;
    assign bus.PENABLE = in_access;
    assign bus.PWRITE  = active & write_q;
    assign bus.PADDR   = active ? addr_q  : '0;
    assign bus.PWDATA  = active ? wdata_q : '0;
    assign {bus.PSEL1, bus.PSEL2} = active ? slave_index(addr_q) : 2'b00;

    assign bus.rsp_valid = done;
    assign bus.rsp_id    = done & owner_q;
    assign bus.rsp_err   = done & (timeout_hit | (bus.PREADY & bus.slverr));
    assign bus.rsp_rdata = (done && bus.PREADY && !write_q) ? bus.PRDATA : '0;

    a_gnt_onehot : assert property (@(posedge PCLK) disable iff (PRESET)
        !(bus.gnt0 && bus.gnt1));

    a_enable_needs_cs : assert property (@(posedge PCLK) disable iff (PRESET)
        bus.PENABLE |-> bus.cs);

    a_no_grant_busy : assert property (@(posedge PCLK) disable iff (PRESET)
        bus.cs |-> !(bus.gnt0 || bus.gnt1));

endmodule

// File: tb/tb_apb_arbiter_master.sv
// Directed bench for apb_arbiter_master: single transfers, wait states, slave
// error, round-robin ordering, reset mid-transfer and the optional timeout.
module tb_apb_arbiter_master;
    import apb_pkg::*;

    logic pclk = 1'b0;
    logic preset;

    int vectors = 0;
    int misses  = 0;

    apb_arbiter_master_if bus ();

    apb_arbiter_master #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK   (pclk),
        .PRESET (preset),
        .bus    (bus)
    );

    always #5 pclk = ~pclk;

    localparam addr_t A1  = 64'h4000_0000_0000_0010;
    localparam data_t D1  = 64'h0000_0000_DEAD_BEEF;
    localparam addr_t A2  = 64'h8000_0000_0000_0020;
    localparam addr_t A3  = 64'hC000_0000_0000_0100;
    localparam addr_t A4  = 64'h0000_0000_0000_0040;
    localparam addr_t A5A = 64'h4000_0000_0000_1000;
    localparam addr_t A5B = 64'h8000_0000_0000_2000;
    localparam addr_t A6  = 64'h0000_0000_0000_0080;

    task automatic check_output(input string tag, input logic [63:0] actual,
                                input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            misses++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic apply_stimulus(input logic r0, input logic w0, input addr_t a0,
                                  input data_t d0, input logic r1, input logic w1,
                                  input addr_t a1, input data_t d1);
        bus.req0   = r0;
        bus.write0 = w0;
        bus.addr0  = a0;
        bus.wdata0 = d0;
        bus.req1   = r1;
        bus.write1 = w1;
        bus.addr1  = a1;
        bus.wdata1 = d1;
        #1;
    endtask

    task automatic slave_response(input logic ready, input logic err, input data_t rdata);
        bus.PREADY = ready;
        bus.slverr = err;
        bus.PRDATA = rdata;
        #1;
    endtask

    task automatic check_idle_bus(input string tag);
        check_output({tag, ".cs"},      bus.cs,      1'b0);
        check_output({tag, ".penable"}, bus.PENABLE, 1'b0);
        check_output({tag, ".psel"},    {bus.PSEL1, bus.PSEL2}, 2'b00);
        check_output({tag, ".pwrite"},  bus.PWRITE,  1'b0);
        check_output({tag, ".paddr"},   bus.PADDR,   64'h0);
        check_output({tag, ".pwdata"},  bus.PWDATA,  64'h0);
        check_output({tag, ".rsp_valid"}, bus.rsp_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with a request pending: nothing may be granted
        preset = 1'b1;
        apply_stimulus(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        slave_response(1'b1, 1'b0, 64'h0);
        repeat (2) tick();
        check_output("reset.gnt0", bus.gnt0, 1'b0);
        check_idle_bus("reset");
        preset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();

        // Zero-wait write from requester 0
        apply_stimulus(1'b1, 1'b1, A1, D1, 1'b0, 1'b0, 64'h0, 64'h0);
        slave_response(1'b1, 1'b0, 64'h5555);
        check_output("wr.gnt0", bus.gnt0, 1'b1);
        check_output("wr.gnt1", bus.gnt1, 1'b0);
        check_output("wr.grant_cs", bus.cs, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        check_output("wr.setup_cs", bus.cs, 1'b1);
        check_output("wr.setup_penable", bus.PENABLE, 1'b0);
        check_output("wr.setup_psel", {bus.PSEL1, bus.PSEL2}, 2'b01);
        check_output("wr.setup_paddr", bus.PADDR, A1);
        check_output("wr.setup_pwdata", bus.PWDATA, D1);
        check_output("wr.setup_pwrite", bus.PWRITE, 1'b1);
        check_output("wr.setup_rsp_valid", bus.rsp_valid, 1'b0);
        tick();
        check_output("wr.access_penable", bus.PENABLE, 1'b1);
        check_output("wr.rsp_valid", bus.rsp_valid, 1'b1);
        check_output("wr.rsp_id", bus.rsp_id, 1'b0);
        check_output("wr.rsp_err", bus.rsp_err, 1'b0);
        check_output("wr.rsp_rdata", bus.rsp_rdata, 64'h0);
        tick();
        check_idle_bus("wr.after");

        // Read from requester 1 with three wait states; requester 0 waits meanwhile
        slave_response(1'b0, 1'b0, 64'h0);
        apply_stimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, A2, 64'h77);
        check_output("rd.gnt1", bus.gnt1, 1'b1);
        check_output("rd.gnt0", bus.gnt0, 1'b0);
        tick();
        apply_stimulus(1'b1, 1'b0, A3, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        check_output("rd.setup_psel", {bus.PSEL1, bus.PSEL2}, 2'b10);
        check_output("rd.setup_pwrite", bus.PWRITE, 1'b0);
        check_output("rd.setup_gnt0", bus.gnt0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) slave_response(1'b1, 1'b0, 64'h1234);
            check_output($sformatf("rd.access%0d_penable", i), bus.PENABLE, 1'b1);
            check_output($sformatf("rd.access%0d_paddr", i), bus.PADDR, A2);
            check_output($sformatf("rd.access%0d_gnt0", i), bus.gnt0, 1'b0);
            check_output($sformatf("rd.access%0d_rsp_valid", i), bus.rsp_valid, (i == 3));
            if (i == 3) begin
                check_output("rd.rsp_rdata", bus.rsp_rdata, 64'h1234);
                check_output("rd.rsp_id", bus.rsp_id, 1'b1);
                check_output("rd.rsp_err", bus.rsp_err, 1'b0);
            end
            tick();
        end

        // Queued requester 0 read is granted on the first IDLE cycle; slave errors
        check_output("err.gnt0", bus.gnt0, 1'b1);
        check_output("err.grant_cs", bus.cs, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        slave_response(1'b0, 1'b1, 64'hFFFF);
        check_output("err.setup_psel", {bus.PSEL1, bus.PSEL2}, 2'b11);
        check_output("err.setup_rsp_err", bus.rsp_err, 1'b0);
        tick();
        slave_response(1'b1, 1'b1, 64'hABCD);
        check_output("err.rsp_valid", bus.rsp_valid, 1'b1);
        check_output("err.rsp_err", bus.rsp_err, 1'b1);
        check_output("err.rsp_id", bus.rsp_id, 1'b0);
        check_output("err.rsp_rdata", bus.rsp_rdata, 64'hABCD);
        tick();
        slave_response(1'b1, 1'b0, 64'h0);
        check_output("err.after_rsp_valid", bus.rsp_valid, 1'b0);
        check_output("err.after_rsp_err", bus.rsp_err, 1'b0);

        // Reset during ACCESS aborts the transfer
        slave_response(1'b0, 1'b0, 64'h0);
        apply_stimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1, A4, 64'h99);
        check_output("abort.gnt1", bus.gnt1, 1'b1);
        tick();
        apply_stimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();
        check_output("abort.in_access", bus.PENABLE, 1'b1);
        preset = 1'b1;
        #1;
        check_idle_bus("abort");
        check_output("abort.gnt", {bus.gnt0, bus.gnt1}, 2'b00);
        slave_response(1'b1, 1'b0, 64'h0);
        tick();
        check_output("abort.held_rsp_valid", bus.rsp_valid, 1'b0);
        preset = 1'b0;
        #1;

        // Both requesters held high: grants alternate starting with requester 0
        for (int t = 0; t < 4; t++) begin
            apply_stimulus(1'b1, 1'b1, A5A, 64'h10, 1'b1, 1'b0, A5B, 64'h20);
            check_output($sformatf("rr%0d.gnt0", t), bus.gnt0, (t % 2 == 0));
            check_output($sformatf("rr%0d.gnt1", t), bus.gnt1, (t % 2 == 1));
            tick();
            check_output($sformatf("rr%0d.setup_gnt", t), {bus.gnt0, bus.gnt1}, 2'b00);
            check_output($sformatf("rr%0d.setup_paddr", t), bus.PADDR,
                         (t % 2 == 1) ? A5B : A5A);
            check_output($sformatf("rr%0d.setup_rsp_valid", t), bus.rsp_valid, 1'b0);
            tick();
            check_output($sformatf("rr%0d.rsp_valid", t), bus.rsp_valid, 1'b1);
            check_output($sformatf("rr%0d.rsp_id", t), bus.rsp_id, (t % 2 == 1));
            tick();
        end
        apply_stimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();

        // Slave never answers
        slave_response(1'b0, 1'b0, 64'hFFFF_0000);
        apply_stimulus(1'b1, 1'b0, A6, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        check_output("stuck.gnt0", bus.gnt0, 1'b1);
        tick();
        apply_stimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();
`ifdef APB_ARBITER_TIMEOUT_EN
        begin
            int seen_at;
            seen_at = 0;
            for (int k = 1; k <= 40; k++) begin
                if (seen_at == 0) begin
                    if (bus.rsp_valid) begin
                        seen_at = k;
                        check_output("timeout.rsp_err", bus.rsp_err, 1'b1);
                        check_output("timeout.rsp_rdata", bus.rsp_rdata, 64'h0);
                        check_output("timeout.rsp_id", bus.rsp_id, 1'b0);
                    end
                    tick();
                end
            end
            check_output("timeout.access_cycles", seen_at, 16);
            check_output("timeout.idle_cs", bus.cs, 1'b0);
            check_output("timeout.idle_penable", bus.PENABLE, 1'b0);
        end
`else
        begin
            logic any_rsp;
            any_rsp = 1'b0;
            for (int c = 2; c < 100; c++) begin
                if (bus.rsp_valid) any_rsp = 1'b1;
                tick();
            end
            check_output("stuck.cycle100_penable", bus.PENABLE, 1'b1);
            check_output("stuck.cycle100_cs", bus.cs, 1'b1);
            check_output("stuck.any_rsp", any_rsp, 1'b0);
            check_output("stuck.cycle100_rsp_valid", bus.rsp_valid, 1'b0);
        end
`endif
        preset = 1'b1;
        tick();
        preset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
